// File: rtl/lw_control_unit.sv
// Multi-cycle LEGv8 control sequencer: 1 EXEC cycle for ALU/branch ops, MEM_A+MEM_D for loads/stores.
// instr_ready is high only in IDLE; words presented while busy are ignored and the latched IR holds until retire.
module lw_control_unit #(
  parameter int          DATA_WIDTH = 64,
  parameter logic [4:0]  FS_ADD     = 5'b01000,
  parameter logic [4:0]  FS_SUB     = 5'b01010
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [4:0]            SA,
  output logic [4:0]            SB,
  output logic [4:0]            DA,
  output logic [4:0]            FS,
  output logic [DATA_WIDTH-1:0] K,
  output logic                  C0,
  output logic                  K_SEL,
  output logic                  PC_SEL,
  output logic                  EN_ALU,
  output logic                  EN_B,
  output logic                  EN_ADDR,
  output logic                  W,
  output logic                  CS,
  output logic                  WE,
  output logic                  OE,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, MEM_A, MEM_D} state_t;
  typedef enum logic [2:0] {OP_ADDI, OP_SUBI, OP_ADD, OP_BR, OP_STUR, OP_LDUR, OP_ILL} op_t;

  state_t      state, state_nxt;
  op_t         op_q, op_dec;
  logic [21:0] ir_q;
  logic        accept;

  logic [4:0]            rd, rn, rm;
  logic [DATA_WIDTH-1:0] k_imm12, k_addr9;

  // Opcode decode on the raw word; only consulted on the accept cycle.
  always_comb begin
    op_dec = OP_ILL;
    if (instr[31:22] == 10'b1001000100) begin
      op_dec = OP_ADDI;
    end else if (instr[31:22] == 10'b1101000100) begin
      op_dec = OP_SUBI;
    end else begin
      case (instr[31:21])
        11'b10001011000: op_dec = OP_ADD;
        11'b11010110000: op_dec = OP_BR;
        11'b11111000000: op_dec = OP_STUR;
        11'b11111000010: op_dec = OP_LDUR;
        default:         op_dec = OP_ILL;
      endcase
    end
  end

  assign instr_ready = rst && (state == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign illegal     = accept && (op_dec == OP_ILL);

  // Only the operand fields are kept; the opcode lives on as op_q.
  assign rd      = ir_q[4:0];
  assign rn      = ir_q[9:5];
  assign rm      = ir_q[20:16];
  assign k_imm12 = {{(DATA_WIDTH-12){1'b0}}, ir_q[21:10]};
  assign k_addr9 = {{(DATA_WIDTH-9){ir_q[20]}}, ir_q[20:12]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op_q  <= OP_ILL;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept && (op_dec != OP_ILL)) begin
        op_q <= op_dec;
        ir_q <= instr[21:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    SA        = 5'd31;
    SB        = 5'd31;
    DA        = 5'd31;
    FS        = 5'd0;
    K         = '0;
    C0        = 1'b0;
    K_SEL     = 1'b0;
    PC_SEL    = 1'b0;
    EN_ALU    = 1'b0;
    EN_B      = 1'b0;
    EN_ADDR   = 1'b0;
    W         = 1'b0;
    CS        = 1'b0;
    WE        = 1'b0;
    OE        = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          case (op_dec)
            OP_ADDI, OP_SUBI, OP_ADD, OP_BR: state_nxt = EXEC;
            OP_STUR, OP_LDUR:                state_nxt = MEM_A;
            default:                         state_nxt = IDLE;
          endcase
        end
      end

      EXEC: begin
        state_nxt = IDLE;
        case (op_q)
          OP_ADDI, OP_SUBI: begin
            SA     = rn;
            DA     = rd;
            K      = k_imm12;
            K_SEL  = 1'b1;
            FS     = (op_q == OP_SUBI) ? FS_SUB : FS_ADD;
            C0     = (op_q == OP_SUBI);
            EN_ALU = 1'b1;
            W      = 1'b1;
            pc_inc = 1'b1;
          end
          OP_ADD: begin
            SA     = rn;
            SB     = rm;
            DA     = rd;
            FS     = FS_ADD;
            EN_ALU = 1'b1;
            W      = 1'b1;
            pc_inc = 1'b1;
          end
          OP_BR: begin
            SA      = rn;
            PC_SEL  = 1'b1;
            pc_load = 1'b1;
          end
          default: ;
        endcase
      end

      MEM_A, MEM_D: begin
        state_nxt = (state == MEM_A) ? MEM_D : IDLE;
        SA        = rn;
        K         = k_addr9;
        K_SEL     = 1'b1;
        FS        = FS_ADD;
        EN_ADDR   = 1'b1;
        CS        = 1'b1;
        pc_inc    = (state == MEM_D);
        if (op_q == OP_STUR) begin
          SB   = rd;
          EN_B = 1'b1;
          WE   = (state == MEM_D);
        end else begin
          DA = rd;
          OE = 1'b1;
          W  = (state == MEM_D);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Datapath bus has a single driver and the PC sees one retire action at a time.
  a_bus_single_driver: assert property (@(posedge clk) disable iff (!rst) $onehot0({EN_ALU, EN_B, OE}));
  a_retire_exclusive:  assert property (@(posedge clk) disable iff (!rst) !(pc_inc && pc_load));

endmodule

// File: tb/tb_lw_control_unit.sv
// Directed bench for lw_control_unit: drives inputs on the falling edge and samples outputs 1 time unit later.
module tb_lw_control_unit;

  localparam int DW = 64;

  localparam logic [12:0] B_C0    = 13'h1000;
  localparam logic [12:0] B_KSEL  = 13'h0800;
  localparam logic [12:0] B_PCSEL = 13'h0400;
  localparam logic [12:0] B_ENALU = 13'h0200;
  localparam logic [12:0] B_ENB   = 13'h0100;
  localparam logic [12:0] B_ENADR = 13'h0080;
  localparam logic [12:0] B_W     = 13'h0040;
  localparam logic [12:0] B_CS    = 13'h0020;
  localparam logic [12:0] B_WE    = 13'h0010;
  localparam logic [12:0] B_OE    = 13'h0008;
  localparam logic [12:0] B_INC   = 13'h0004;
  localparam logic [12:0] B_LOAD  = 13'h0002;
  localparam logic [12:0] B_ILL   = 13'h0001;

  logic          clk;
  logic          rst;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [4:0]    SA, SB, DA, FS;
  logic [DW-1:0] K;
  logic          C0, K_SEL, PC_SEL, EN_ALU, EN_B, EN_ADDR, W, CS, WE, OE;
  logic          pc_inc, pc_load, illegal;

  logic [33:0]   ctl;
  logic [33:0]   exp_v;
  int            n_checks;
  int            n_fail;

  assign ctl = {instr_ready, SA, SB, DA, FS, C0, K_SEL, PC_SEL, EN_ALU, EN_B, EN_ADDR,
                W, CS, WE, OE, pc_inc, pc_load, illegal};

  lw_control_unit #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .SA          (SA),
    .SB          (SB),
    .DA          (DA),
    .FS          (FS),
    .K           (K),
    .C0          (C0),
    .K_SEL       (K_SEL),
    .PC_SEL      (PC_SEL),
    .EN_ALU      (EN_ALU),
    .EN_B        (EN_B),
    .EN_ADDR     (EN_ADDR),
    .W           (W),
    .CS          (CS),
    .WE          (WE),
    .OE          (OE),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] ex(input logic rdy, input logic [4:0] sa, input logic [4:0] sb,
                                     input logic [4:0] da, input logic [4:0] fs, input logic [12:0] bits);
    return {rdy, sa, sb, da, fs, bits};
  endfunction

  task test_reset;
    #1;
    exp_v = ex(1'b0, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL reset_ctl: got %h want %h", ctl, exp_v); end
    n_checks++;
    if (K !== 64'd0) begin n_fail++; $display("FAIL reset_k: got %h want %h", K, 64'd0); end
    @(negedge clk); rst = 1'b1; #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL reset_release: got %h want %h", ctl, exp_v); end
  endtask

  task test_addi;
    @(negedge clk); instr = 32'h91003FE0; instr_valid = 1'b1; #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL addi_accept: got %h want %h", ctl, exp_v); end
    @(negedge clk); instr_valid = 1'b0; instr = 32'h0; #1;
    exp_v = ex(1'b0, 5'd31, 5'd31, 5'd0, 5'b01000, B_KSEL | B_ENALU | B_W | B_INC);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL addi_exec: got %h want %h", ctl, exp_v); end
    n_checks++;
    if (K !== 64'h0F) begin n_fail++; $display("FAIL addi_k: got %h want %h", K, 64'h0F); end
    @(negedge clk); #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL addi_retire: got %h want %h", ctl, exp_v); end
  endtask

  task test_subi;
    // SUBI X3, X4, #1
    @(negedge clk); instr = 32'hD1000483; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0; #1;
    exp_v = ex(1'b0, 5'd4, 5'd31, 5'd3, 5'b01010, B_C0 | B_KSEL | B_ENALU | B_W | B_INC);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL subi_exec: got %h want %h", ctl, exp_v); end
    n_checks++;
    if (K !== 64'd1) begin n_fail++; $display("FAIL subi_k: got %h want %h", K, 64'd1); end
    @(negedge clk); #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL subi_retire: got %h want %h", ctl, exp_v); end
  endtask

  task test_add;
    // ADD X5, X1, X2
    @(negedge clk); instr = 32'h8B020025; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0; #1;
    exp_v = ex(1'b0, 5'd1, 5'd2, 5'd5, 5'b01000, B_ENALU | B_W | B_INC);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL add_exec: got %h want %h", ctl, exp_v); end
    @(negedge clk); #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL add_retire: got %h want %h", ctl, exp_v); end
  endtask

  task test_br;
    @(negedge clk); instr = 32'hD61F00C0; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0; #1;
    exp_v = ex(1'b0, 5'd6, 5'd31, 5'd31, 5'd0, B_PCSEL | B_LOAD);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL br_exec: got %h want %h", ctl, exp_v); end
    @(negedge clk); #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL br_retire: got %h want %h", ctl, exp_v); end
  endtask

  task test_stur;
    @(negedge clk); instr = 32'hF8000002; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0; #1;
    exp_v = ex(1'b0, 5'd0, 5'd2, 5'd31, 5'b01000, B_KSEL | B_ENADR | B_ENB | B_CS);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL stur_mem_a: got %h want %h", ctl, exp_v); end
    n_checks++;
    if (K !== 64'd0) begin n_fail++; $display("FAIL stur_k: got %h want %h", K, 64'd0); end
    @(negedge clk); #1;
    exp_v = ex(1'b0, 5'd0, 5'd2, 5'd31, 5'b01000, B_KSEL | B_ENADR | B_ENB | B_CS | B_WE | B_INC);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL stur_mem_d: got %h want %h", ctl, exp_v); end
    @(negedge clk); #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL stur_retire: got %h want %h", ctl, exp_v); end
  endtask

  task test_ldur;
    @(negedge clk); instr = 32'hF85F8026; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0; #1;
    exp_v = ex(1'b0, 5'd1, 5'd31, 5'd6, 5'b01000, B_KSEL | B_ENADR | B_CS | B_OE);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL ldur_mem_a: got %h want %h", ctl, exp_v); end
    n_checks++;
    if (K !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      n_fail++; $display("FAIL ldur_k: got %h want %h", K, 64'hFFFF_FFFF_FFFF_FFF8);
    end
    @(negedge clk); #1;
    exp_v = ex(1'b0, 5'd1, 5'd31, 5'd6, 5'b01000, B_KSEL | B_ENADR | B_CS | B_OE | B_W | B_INC);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL ldur_mem_d: got %h want %h", ctl, exp_v); end
    @(negedge clk); #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL ldur_retire: got %h want %h", ctl, exp_v); end
  endtask

  task test_illegal;
    @(negedge clk); instr = 32'h0000_0000; instr_valid = 1'b1; #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, B_ILL);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL illegal_pulse: got %h want %h", ctl, exp_v); end
    @(negedge clk); instr_valid = 1'b0; #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL illegal_after: got %h want %h", ctl, exp_v); end
  endtask

  task test_back_to_back;
    // ADDI X0,X31,#15, then a busy-cycle word change to ADD X5,X1,X2 that must wait for ready.
    @(negedge clk); instr = 32'h91003FE0; instr_valid = 1'b1;
    @(negedge clk); instr = 32'h8B020025; #1;
    exp_v = ex(1'b0, 5'd31, 5'd31, 5'd0, 5'b01000, B_KSEL | B_ENALU | B_W | B_INC);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL b2b_busy_ignore: got %h want %h", ctl, exp_v); end
    @(negedge clk); #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL b2b_second_accept: got %h want %h", ctl, exp_v); end
    @(negedge clk); instr_valid = 1'b0; #1;
    exp_v = ex(1'b0, 5'd1, 5'd2, 5'd5, 5'b01000, B_ENALU | B_W | B_INC);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL b2b_second_exec: got %h want %h", ctl, exp_v); end
    @(negedge clk); #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL b2b_retire: got %h want %h", ctl, exp_v); end
  endtask

  task test_rst_mid_op;
    @(negedge clk); instr = 32'hF8000002; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0; #1;
    exp_v = ex(1'b0, 5'd0, 5'd2, 5'd31, 5'b01000, B_KSEL | B_ENADR | B_ENB | B_CS);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL rst_pre_mem_a: got %h want %h", ctl, exp_v); end
    #1 rst = 1'b0;
    #1;
    exp_v = ex(1'b0, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL rst_async_drop: got %h want %h", ctl, exp_v); end
    @(negedge clk); rst = 1'b1; #1;
    exp_v = ex(1'b1, 5'd31, 5'd31, 5'd31, 5'd0, 13'h0);
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL rst_release_idle: got %h want %h", ctl, exp_v); end
    @(negedge clk); #1;
    n_checks++;
    if (ctl !== exp_v) begin n_fail++; $display("FAIL rst_no_retire: got %h want %h", ctl, exp_v); end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    instr       = 32'h0;
    instr_valid = 1'b0;
    #2 rst = 1'b0;
    test_reset();
    test_addi();
    test_subi();
    test_add();
    test_br();
    test_stur();
    test_ldur();
    test_illegal();
    test_back_to_back();
    test_rst_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
